hazard_control: RTL

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control_pkg.sv | 25 ++
 rtl/hazard_perf_counters.sv | 45 ++++
 rtl/hazard_control.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_pkg.sv
// -----------------------------------------------------------------------------
// hazard_control_pkg
//   Shared definitions for the pipeline hazard controller:
//     hz_state_t             - controller FSM state encoding (RUN, MD_WAIT, MEM_WAIT)
//     HZ_MD_TIMEOUT_DEFAULT  - default mul/div wait limit in cycles
//     HZ_PERF_W              - width of the optional performance counters
//     hz_cnt_width()         - width needed for a 0..n-1 cycle counter
// -----------------------------------------------------------------------------
package hazard_control_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int HZ_MD_TIMEOUT_DEFAULT = 64;
    localparam int HZ_PERF_W             = 32;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int hz_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// -----------------------------------------------------------------------------
// hazard_perf_counters
//   Free-running, wrap-around event counters for the hazard controller.
//   Only instantiated when HAZARD_PERF_EN is defined.
//   Ports:
//     clk, rstn          - clock, asynchronous active-low reset (clears counters)
//     pc_stall_i         - counted into stall_cycles_o once per cycle
//     if_id_flush_i      - counted into flush_count_o once per cycle
//     load_use_i         - counted into loaduse_count_o once per cycle
// -----------------------------------------------------------------------------
module hazard_perf_counters
    import hazard_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 pc_stall_i,
    input  logic                 if_id_flush_i,
    input  logic                 load_use_i,
    output logic [HZ_PERF_W-1:0] stall_cycles_o,
    output logic [HZ_PERF_W-1:0] flush_count_o,
    output logic [HZ_PERF_W-1:0] loaduse_count_o
);

    logic [HZ_PERF_W-1:0] stall_cycles_q;
    logic [HZ_PERF_W-1:0] flush_count_q;
    logic [HZ_PERF_W-1:0] loaduse_count_q;

    // Counters wrap naturally at 2^HZ_PERF_W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
            loaduse_count_q <= '0;
        end else begin
            if (pc_stall_i)    stall_cycles_q  <= stall_cycles_q + 1'b1;
            if (if_id_flush_i) flush_count_q   <= flush_count_q + 1'b1;
            if (load_use_i)    loaduse_count_q <= loaduse_count_q + 1'b1;
        end
    end

    assign stall_cycles_o  = stall_cycles_q;
    assign flush_count_o   = flush_count_q;
    assign loaduse_count_o = loaduse_count_q;

endmodule

// File: rtl/hazard_control.sv
// -----------------------------------------------------------------------------
// hazard_control
//   Stall / flush / bubble generation for a 5-stage in-order pipeline.
//   Handles memory wait states, multi-cycle mul/div with a watchdog timeout,
//   control redirects and load-use hazards, in that priority order.
//
//   Parameters:
//     REG_ADDR_W   - register index width
//     MD_TIMEOUT   - max cycles spent in MD_WAIT before giving up
//   Ports:
//     clk, rstn                         - clock, asynchronous active-low reset
//     id_rs1/id_rs2, id_uses_rs1/2      - ID-stage source registers and valids
//     ex_rd, ex_reg_write, ex_mem_read  - EX-stage destination / load info
//     ex_redirect                       - taken branch/jump resolved in EX
//     ex_md_start, md_done              - mul/div start in EX, result ready
//     dmem_req, dmem_ready              - MEM-stage access handshake
//     pc/if_id/id_ex/ex_mem_stall       - hold the corresponding registers
//     if_id_flush, id_ex_flush          - turn the stage register into a bubble
//     mem_wb_bubble                     - invalidate the MEM->WB transfer
//     md_timeout                        - sticky mul/div timeout error
//   Configuration:
//     HAZARD_PERF_EN - adds stall_cycles, flush_count, loaduse_count outputs
// -----------------------------------------------------------------------------
module hazard_control
    import hazard_control_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MD_TIMEOUT = HZ_MD_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  ex_md_start,
    input  logic                  md_done,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_stall,
    output logic                  ex_mem_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_bubble,
    output logic                  md_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [HZ_PERF_W-1:0]  stall_cycles,
    output logic [HZ_PERF_W-1:0]  flush_count,
    output logic [HZ_PERF_W-1:0]  loaduse_count
`endif
);

    localparam int              CNT_W   = hz_cnt_width(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_TIMEOUT - 1);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_timeout_q, md_timeout_d;

    logic in_run, in_md;
    logic mem_stall, md_stall, rd_hit, lu_stall, md_expire;

    assign in_run = (state_q == RUN);
    assign in_md  = (state_q == MD_WAIT);

    assign mem_stall = dmem_req & ~dmem_ready;
    assign md_stall  = (in_run & ex_md_start) | (in_md & ~md_done);

    // A load writing x0 never creates a dependency.
    assign rd_hit = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                    (((ex_rd == id_rs1) & id_uses_rs1) |
                     ((ex_rd == id_rs2) & id_uses_rs2));

    // Load-use is the lowest priority hazard; a redirect kills the dependent
    // instruction anyway, so it suppresses the load-use stall.
    assign lu_stall = rstn & in_run & ~mem_stall & ~md_stall & ~ex_redirect & rd_hit;

    assign md_expire = in_md & ~md_done & (md_cnt_q == MD_LAST);

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;

        if (mem_stall) begin
            // A memory wait pre-empts whatever the controller was doing.
            state_d = MEM_WAIT;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_md_start & ~md_done) begin
                        state_d  = MD_WAIT;
                        md_cnt_d = '0;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        state_d = RUN;
                    end else if (md_expire) begin
                        state_d      = RUN;
                        md_timeout_d = 1'b1;
                    end else begin
                        md_cnt_d = md_cnt_q + 1'b1;
                    end
                end
                MEM_WAIT: state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= RUN;
            md_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stall / flush outputs (combinational, same-cycle)
    // -------------------------------------------------------------------------
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;

        // The outputs are combinational from live inputs, so they are forced
        // low explicitly while reset is held rather than relying on state.
        if (!rstn) begin
            pc_stall = 1'b0;
        end else if (mem_stall) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (md_stall) begin
            // EX holds the mul/div; later stages keep draining.
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu_stall) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end

        // A held stage register must keep its contents, so a stall masks flush.
        if_id_flush = if_id_flush & ~if_id_stall;
        id_ex_flush = id_ex_flush & ~id_ex_stall;
    end

    assign md_timeout = md_timeout_q;

`ifdef HAZARD_PERF_EN
    hazard_perf_counters u_perf (
        .clk             (clk),
        .rstn            (rstn),
        .pc_stall_i      (pc_stall),
        .if_id_flush_i   (if_id_flush),
        .load_use_i      (lu_stall),
        .stall_cycles_o  (stall_cycles),
        .flush_count_o   (flush_count),
        .loaduse_count_o (loaduse_count)
    );
`endif

endmodule
